// File: rtl/pwm_multi_gen_pkg.sv
// Shared defaults and encodings for the multi-generator PWM peripheral.
// Active TOP resets to all-ones so an unconfigured generator runs its longest period.
package pwm_multi_gen_pkg;

    localparam int DEF_N_GEN = 2;
    localparam int DEF_N_CH  = 2;
    localparam int DEF_N_OUT = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_DIV_W = 4;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    // Prescaler must reach 2^(2^div_w - 1) - 1 for the largest exponent.
    function automatic int pre_width(input int div_w);
        return (1 << div_w) - 1;
    endfunction

endpackage

// File: rtl/pwm_multi_gen_core.sv
// One PWM generator: prescaler, edge/center counter, shadowed configuration
// committed only at period boundaries, and N_CH compare channels.
module pwm_multi_gen_core
    import pwm_multi_gen_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_center,
    input  logic [DIV_W-1:0]      i_div,
    input  logic [CNT_W-1:0]      i_top,
    input  logic [N_CH*CNT_W-1:0] i_duty,
    input  logic                  i_cfg_load,
    output logic                  o_pending,
    output logic                  o_period_start,
    output logic [N_CH-1:0]       o_ch_sig
);

    localparam int PRE_W = pre_width(DIV_W);

    logic [PRE_W-1:0]      r_pre;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_down;
    logic                  r_pending;
    logic                  r_pstart;
    logic [CNT_W-1:0]      r_top;
    logic [N_CH*CNT_W-1:0] r_duty;
    logic [DIV_W-1:0]      r_div;
    pwm_mode_e             r_mode;

    logic [PRE_W-1:0] w_pre_max;
    logic             w_tick;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_down_nxt;
    logic             w_boundary;
    logic             w_commit;

    assign w_pre_max = ~({PRE_W{1'b1}} << r_div);
    assign w_tick    = (r_pre == w_pre_max);

    always_comb begin
        w_cnt_nxt  = '0;
        w_down_nxt = 1'b0;
        if (r_mode == MODE_EDGE) begin
            w_cnt_nxt = (r_cnt == r_top) ? '0 : r_cnt + 1'b1;
        end else if (r_top == '0) begin
            w_cnt_nxt = '0;
        end else if (!r_down && (r_cnt != r_top)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else begin
            w_cnt_nxt  = r_cnt - 1'b1;
            w_down_nxt = (w_cnt_nxt != '0);
        end
    end

    // In both modes the boundary is exactly the tick whose next count is 0.
    assign w_boundary = i_en & w_tick & (w_cnt_nxt == '0);
    assign w_commit   = (r_pending | i_cfg_load) & (w_boundary | ~i_en);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre     <= '0;
            r_cnt     <= '0;
            r_down    <= 1'b0;
            r_pending <= 1'b0;
            r_pstart  <= 1'b0;
            r_top     <= '1;
            r_duty    <= '0;
            r_div     <= '0;
            r_mode    <= MODE_EDGE;
        end else begin
            r_pstart <= w_boundary;
            if (w_commit) begin
                r_top     <= i_top;
                r_duty    <= i_duty;
                r_div     <= i_div;
                r_mode    <= pwm_mode_e'(i_center);
                r_pending <= 1'b0;
                r_pre     <= '0;
                r_cnt     <= '0;
                r_down    <= 1'b0;
            end else begin
                r_pending <= r_pending | i_cfg_load;
                if (!i_en) begin
                    r_pre  <= '0;
                    r_cnt  <= '0;
                    r_down <= 1'b0;
                end else if (w_tick) begin
                    r_pre  <= '0;
                    r_cnt  <= w_cnt_nxt;
                    r_down <= w_down_nxt;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_ch_sig = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_ch_sig[c] = i_en & (r_cnt < r_duty[c*CNT_W +: CNT_W]);
        end
    end

    assign o_pending      = r_pending;
    assign o_period_start = r_pstart;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-generator PWM peripheral: N_GEN generator cores whose channels are
// routed to N_OUT registered pins through a per-pin source select.
module pwm_multi_gen
    import pwm_multi_gen_pkg::*;
#(
    parameter int N_GEN = DEF_N_GEN,
    parameter int N_CH  = DEF_N_CH,
    parameter int N_OUT = DEF_N_OUT,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DIV_W = DEF_DIV_W,
    parameter int SEL_W = $clog2(N_GEN*N_CH)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [N_GEN-1:0]            i_gen_en,
    input  logic [N_GEN-1:0]            i_gen_center,
    input  logic [N_GEN*DIV_W-1:0]      i_gen_div,
    input  logic [N_GEN*CNT_W-1:0]      i_gen_top,
    input  logic [N_GEN*N_CH*CNT_W-1:0] i_duty,
    input  logic [N_GEN-1:0]            i_cfg_load,
    input  logic [N_OUT-1:0]            i_en_out,
    input  logic [N_OUT-1:0]            i_en_pwm_out,
    input  logic [N_OUT*SEL_W-1:0]      i_out_sel,
    output logic [N_GEN-1:0]            o_cfg_pending,
    output logic [N_GEN-1:0]            o_period_start,
    output logic [N_OUT-1:0]            o_out
);

    localparam int N_SRC = N_GEN * N_CH;

    logic [N_SRC-1:0]        w_sig;
    logic [(1<<SEL_W)-1:0]   w_sig_ext;
    logic [N_OUT-1:0]        r_out;

    for (genvar g = 0; g < N_GEN; g++) begin : g_gen
        pwm_multi_gen_core #(
            .N_CH  (N_CH),
            .CNT_W (CNT_W),
            .DIV_W (DIV_W)
        ) u_core (
            .i_clk          (i_clk),
            .i_rst_n        (i_rst_n),
            .i_en           (i_gen_en[g]),
            .i_center       (i_gen_center[g]),
            .i_div          (i_gen_div[g*DIV_W +: DIV_W]),
            .i_top          (i_gen_top[g*CNT_W +: CNT_W]),
            .i_duty         (i_duty[g*N_CH*CNT_W +: N_CH*CNT_W]),
            .i_cfg_load     (i_cfg_load[g]),
            .o_pending      (o_cfg_pending[g]),
            .o_period_start (o_period_start[g]),
            .o_ch_sig       (w_sig[g*N_CH +: N_CH])
        );
    end

    // Unused select codes read a zero-padded source vector.
    always_comb begin
        w_sig_ext            = '0;
        w_sig_ext[N_SRC-1:0] = w_sig;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                r_out[i] <= (i_en_out[i] & i_en_pwm_out[i]) ?
                            w_sig_ext[i_out_sel[i*SEL_W +: SEL_W]] : i_en_out[i];
            end
        end
    end

    assign o_out = r_out;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: phase-based reference model checked
// every cycle, hand-derived period patterns, and a table of static corner cases.
module tb_pwm_multi_gen;

    localparam int G  = 2;
    localparam int C  = 2;
    localparam int NO = 8;
    localparam int CW = 8;
    localparam int DW = 4;
    localparam int SW = 3;
    localparam int NS = G * C;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [G-1:0]      gen_en, gen_center, cfg_load;
    logic [G*DW-1:0]   gen_div;
    logic [G*CW-1:0]   gen_top;
    logic [NS*CW-1:0]  duty;
    logic [NO-1:0]     en_out, en_pwm;
    logic [NO*SW-1:0]  out_sel;
    logic [G-1:0]      cfg_pending, period_start;
    logic [NO-1:0]     out;

    pwm_multi_gen #(
        .N_GEN(G), .N_CH(C), .N_OUT(NO), .CNT_W(CW), .DIV_W(DW), .SEL_W(SW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_gen_en       (gen_en),
        .i_gen_center   (gen_center),
        .i_gen_div      (gen_div),
        .i_gen_top      (gen_top),
        .i_duty         (duty),
        .i_cfg_load     (cfg_load),
        .i_en_out       (en_out),
        .i_en_pwm_out   (en_pwm),
        .i_out_sel      (out_sel),
        .o_cfg_pending  (cfg_pending),
        .o_period_start (period_start),
        .o_out          (out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the period rather than an up/down counter.
    int          m_pre[G], m_phase[G], m_top[G], m_div[G], m_duty[NS];
    logic [G-1:0] m_ctr, m_pend, m_ps;
    logic [NO-1:0] m_out;

    typedef struct {
        logic       eo;
        logic       ep;
        logic [2:0] sel;
        int         dty;
        logic       exp;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_cnt(input int g);
        if (m_ctr[g] && (m_phase[g] > m_top[g])) return 2 * m_top[g] - m_phase[g];
        return m_phase[g];
    endfunction

    task automatic model_reset();
        for (int g = 0; g < G; g++) begin
            m_pre[g] = 0; m_phase[g] = 0; m_top[g] = 255; m_div[g] = 0;
        end
        for (int s = 0; s < NS; s++) m_duty[s] = 0;
        m_ctr = '0; m_pend = '0; m_ps = '0; m_out = '0;
    endtask

    task automatic model_step();
        logic [NS-1:0] sig;
        for (int g = 0; g < G; g++)
            for (int c = 0; c < C; c++)
                sig[g*C+c] = gen_en[g] && (m_cnt(g) < m_duty[g*C+c]);
        for (int i = 0; i < NO; i++) begin
            int s;
            logic v;
            s = int'(out_sel[i*SW +: SW]);
            v = (s < NS) ? sig[s] : 1'b0;
            m_out[i] = (en_out[i] && en_pwm[i]) ? v : en_out[i];
        end
        for (int g = 0; g < G; g++) begin
            int   per;
            logic tick, bnd;
            per  = m_ctr[g] ? ((m_top[g] == 0) ? 1 : 2 * m_top[g]) : m_top[g] + 1;
            tick = (m_pre[g] == (1 << m_div[g]) - 1);
            bnd  = gen_en[g] && tick && (m_phase[g] == per - 1);
            m_ps[g] = bnd;
            if ((m_pend[g] || cfg_load[g]) && (bnd || !gen_en[g])) begin
                m_top[g] = int'(gen_top[g*CW +: CW]);
                m_div[g] = int'(gen_div[g*DW +: DW]);
                m_ctr[g] = gen_center[g];
                for (int c = 0; c < C; c++) m_duty[g*C+c] = int'(duty[(g*C+c)*CW +: CW]);
                m_pre[g] = 0; m_phase[g] = 0; m_pend[g] = 1'b0;
            end else begin
                if (cfg_load[g]) m_pend[g] = 1'b1;
                if (!gen_en[g]) begin
                    m_pre[g] = 0; m_phase[g] = 0;
                end else if (tick) begin
                    m_pre[g] = 0; m_phase[g] = (m_phase[g] + 1) % per;
                end else begin
                    m_pre[g]++;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("out", int'(out), int'(m_out));
        chk("pending", int'(cfg_pending), int'(m_pend));
        chk("pstart", int'(period_start), int'(m_ps));
    endtask

    task automatic set_gen(input int g, input int top, input int d0, input int d1,
                           input int dv, input logic ctr);
        gen_top[g*CW +: CW]       = CW'(top);
        duty[(g*C)*CW +: CW]      = CW'(d0);
        duty[(g*C+1)*CW +: CW]    = CW'(d1);
        gen_div[g*DW +: DW]       = DW'(dv);
        gen_center[g]             = ctr;
    endtask

    task automatic pulse_load(input logic [G-1:0] m);
        cfg_load = m;
        cyc();
        cfg_load = '0;
    endtask

    task automatic wait_ps(input int g);
        int n = 0;
        while (!period_start[g] && n < 2000) begin
            cyc();
            n++;
        end
        chk("ps_wait", int'(period_start[g]), 1);
    endtask

    task automatic run_window(input int p, output logic [31:0] pat, output int ps_at);
        pat = '0;
        ps_at = 0;
        for (int k = 1; k <= p; k++) begin
            cyc();
            pat[k-1] = out[0];
            if (period_start[0] && ps_at == 0) ps_at = k;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] pat;
        int ps_at, hi, bad;

        vt[0] = '{1'b1, 1'b1, 3'd0, 0,   1'b0};
        vt[1] = '{1'b1, 1'b1, 3'd0, 10,  1'b1};
        vt[2] = '{1'b1, 1'b1, 3'd0, 255, 1'b1};
        vt[3] = '{1'b1, 1'b1, 3'd7, 3,   1'b0};
        vt[4] = '{1'b1, 1'b1, 3'd5, 3,   1'b0};
        vt[5] = '{1'b1, 1'b0, 3'd0, 3,   1'b1};
        vt[6] = '{1'b0, 1'b1, 3'd0, 3,   1'b0};
        vt[7] = '{1'b0, 1'b0, 3'd0, 3,   1'b0};

        rst_n = 1'b0;
        gen_en = '0; gen_center = '0; cfg_load = '0; gen_div = '0; gen_top = '0;
        duty = '0; en_out = '0; en_pwm = '0; out_sel = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_pending", int'(cfg_pending), 0);
        chk("rst_pstart", int'(period_start), 0);
        rst_n = 1'b1;

        // Edge mode, TOP=9, duty 3
        en_out[0] = 1'b1; en_pwm[0] = 1'b1;
        gen_en = 2'b11;
        set_gen(0, 9, 3, 0, 0, 1'b0);
        pulse_load(2'b01);
        chk("edge_pending", int'(cfg_pending[0]), 1);
        wait_ps(0);
        chk("edge_committed", int'(cfg_pending[0]), 0);
        run_window(10, pat, ps_at);
        chk("edge_pat", int'(pat), 32'h007);
        chk("edge_period", ps_at, 10);
        run_window(10, pat, ps_at);
        chk("edge_pat2", int'(pat), 32'h007);

        // Mid-period duty change 3 -> 7
        hi = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) begin
                duty[0 +: CW] = 8'd7;
                cfg_load = 2'b01;
            end
            cyc();
            cfg_load = '0;
            if (k >= 5 && k <= 9) chk("upd_pending", int'(cfg_pending[0]), 1);
            hi += int'(out[0]);
        end
        chk("upd_old_hi", hi, 3);
        chk("upd_pend_clr", int'(cfg_pending[0]), 0);
        chk("upd_ps", int'(period_start[0]), 1);
        run_window(10, pat, ps_at);
        chk("upd_new_pat", int'(pat), 32'h07F);

        // Center mode, TOP=4, duty 2
        set_gen(0, 4, 2, 0, 0, 1'b1);
        pulse_load(2'b01);
        wait_ps(0);
        run_window(8, pat, ps_at);
        chk("ctr_pat", int'(pat), 32'h083);
        chk("ctr_period", ps_at, 8);

        // Prescaler div=2, then commit div=0 mid-period
        set_gen(0, 3, 2, 0, 2, 1'b0);
        pulse_load(2'b01);
        wait_ps(0);
        run_window(16, pat, ps_at);
        chk("pre_pat", int'(pat), 32'h00FF);
        chk("pre_period", ps_at, 16);
        set_gen(0, 3, 2, 0, 0, 1'b0);
        pat = '0; ps_at = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) cfg_load = 2'b01;
            cyc();
            cfg_load = '0;
            pat[k-1] = out[0];
            if (period_start[0] && ps_at == 0) ps_at = k;
        end
        chk("pre_old_pat", int'(pat), 32'h00FF);
        chk("pre_old_period", ps_at, 16);
        run_window(4, pat, ps_at);
        chk("pre_new_pat", int'(pat), 32'h3);
        chk("pre_new_period", ps_at, 4);

        // Disabled generator with a pending commit
        set_gen(0, 9, 5, 0, 0, 1'b0);
        pulse_load(2'b01);
        chk("dis_pending", int'(cfg_pending[0]), 1);
        gen_en[0] = 1'b0;
        cyc();
        chk("dis_applied", int'(cfg_pending[0]), 0);
        cyc();
        chk("dis_out", int'(out[0]), 0);
        gen_en[0] = 1'b1;
        run_window(10, pat, ps_at);
        chk("reen_pat", int'(pat), 32'h01F);
        chk("reen_period", ps_at, 10);

        // Static corner table on pin 0 (gen0 TOP=9)
        for (int i = 0; i < 8; i++) begin
            set_gen(0, 9, vt[i].dty, 0, 0, 1'b0);
            pulse_load(2'b01);
            wait_ps(0);
            en_out[0] = vt[i].eo;
            en_pwm[0] = vt[i].ep;
            out_sel[0 +: SW] = vt[i].sel;
            cyc();
            bad = 0;
            repeat (12) begin
                cyc();
                if (out[0] != vt[i].exp) bad++;
            end
            chk($sformatf("vec%0d_bad_cycles", i), bad, 0);
        end
        en_out[0] = 1'b1; en_pwm[0] = 1'b1; out_sel[0 +: SW] = '0;

        // Async reset mid-period with pending and a static-high pin
        set_gen(0, 9, 5, 0, 0, 1'b0);
        pulse_load(2'b01);
        wait_ps(0);
        en_out[1] = 1'b1; en_pwm[1] = 1'b0;
        repeat (4) cyc();
        pulse_load(2'b10);
        chk("pre_rst_pending", int'(cfg_pending[1]), 1);
        chk("pre_rst_pin1", int'(out[1]), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out", int'(out), 0);
        chk("arst_pending", int'(cfg_pending), 0);
        chk("arst_pstart", int'(period_start), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hi = 0;
        repeat (20) begin
            cyc();
            hi += int'(out[0]);
        end
        chk("post_rst_duty0", hi, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int g = 0; g < G; g++) begin
                if ($urandom_range(0, 29) == 0) begin
                    int t;
                    t = int'($urandom_range(0, 12));
                    set_gen(g, t, int'($urandom_range(0, t + 2)), int'($urandom_range(0, t + 2)),
                            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
                end
                cfg_load[g] = ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 199) == 0) gen_en[g] = ~gen_en[g];
            end
            if ($urandom_range(0, 49) == 0) begin
                en_out  = NO'($urandom);
                en_pwm  = NO'($urandom);
                out_sel = (NO*SW)'($urandom);
            end
            cyc();
        end
        cfg_load = '0;
        repeat (5) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
